// File: rtl/truth_table_probe_pkg.sv
// Shared types and helpers for the truth-table probe.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tt_probe_pkg;

  // Default circuit width: 3-input gates give an 8-bit code.
  localparam int TT_N_IN   = 3;
  localparam int TT_CODE_W = 1 << TT_N_IN;

  // Sweep controller states; the enum gives readable names, the
  // localparam copies keep plain logic [1:0] comparisons in the FSM.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } tt_state_e;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SWEEP = SWEEP;
  localparam logic [1:0] ST_DONE  = DONE;

  // Row 0 of the truth table lands in the MSB of the code.
  function automatic int code_bit_index(input int idx, input int n_in);
    return (1 << n_in) - 1 - idx;
  endfunction

  function automatic int code_width(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/truth_table_probe_if.sv
// Bundle between the probe and the harness / circuit under test.
// Latency: n/a (wires only).
// Backpressure: none; start is simply ignored while a sweep runs.
interface truth_table_probe_if
  import tt_probe_pkg::*;
#(
  parameter int N_IN = TT_N_IN
);
  localparam int CODE_W = code_width(N_IN);

  logic              start;
  logic              probe_out;
  logic [CODE_W-1:0] expected_code;
  logic [N_IN-1:0]   probe_in;
  logic              busy;
  logic              done;
  logic [CODE_W-1:0] code;
  logic              code_valid;
  logic              match;
  logic [CODE_W-1:0] mismatch_mask;

  // Harness side: requests sweeps and models the circuit under test.
  modport master (
    output start, probe_out, expected_code,
    input  probe_in, busy, done, code, code_valid, match, mismatch_mask
  );

  // Probe side.
  modport slave (
    input  start, probe_out, expected_code,
    output probe_in, busy, done, code, code_valid, match, mismatch_mask
  );

endinterface

// File: rtl/truth_table_probe_settle_timer.sv
// Settle counter: ticks once every SETTLE_CYCLES enabled cycles.
// Latency: tick is combinational on the terminal count.
// Backpressure: none; clear overrides enable.
module settle_timer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(SETTLE_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == TERM);

  // Count enabled cycles, wrapping to zero on the terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/truth_table_probe.sv
// Sweeps all 2**N_IN input vectors of a combinational circuit and builds its truth-table code.
// Latency: start to done = (2**N_IN)*SETTLE_CYCLES cycles; done is a one-cycle pulse.
// Backpressure: none; start is honoured only in IDLE, never queued.
module truth_table_probe
  import tt_probe_pkg::*;
#(
  parameter int N_IN          = TT_N_IN,
  parameter int SETTLE_CYCLES = 4
) (
  input logic               clk,
  input logic               rst,
  truth_table_probe_if.slave bus
);
  localparam int CODE_W = code_width(N_IN);
  localparam logic [N_IN:0] LAST_IDX = (N_IN + 1)'(CODE_W - 1);

  logic [1:0]        state;
  logic [N_IN:0]     index;
  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] exp_q;
  logic              valid_q;
  logic              tick;
  logic [N_IN-1:0]   bit_idx;

  // Code bit that the current vector's sample lands in (row 0 -> MSB).
  assign bit_idx = N_IN'(code_bit_index(int'(index), N_IN));

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != ST_SWEEP),
    .enable (state == ST_SWEEP),
    .tick   (tick)
  );

  // Sweep controller: capture on start, sample each vector on its last settle cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      index   <= '0;
      code_q  <= '0;
      exp_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state   <= ST_SWEEP;
            index   <= '0;
            code_q  <= '0;
            exp_q   <= bus.expected_code;
            valid_q <= 1'b0;
          end
        end
        ST_SWEEP: begin
          if (tick) begin
            code_q[bit_idx] <= bus.probe_out;
            if (index == LAST_IDX) begin
              state   <= ST_DONE;
              valid_q <= 1'b1;
            end else begin
              index <= index + 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Index stays on the last vector through DONE, so probe_in holds all ones there.
  assign bus.probe_in      = (state == ST_IDLE) ? '0 : index[N_IN-1:0];
  assign bus.busy          = (state == ST_SWEEP);
  assign bus.done          = (state == ST_DONE);
  assign bus.code          = code_q;
  assign bus.code_valid    = valid_q;
  assign bus.match         = valid_q && (code_q == exp_q);
  assign bus.mismatch_mask = valid_q ? (code_q ^ exp_q) : '0;

endmodule

// File: doc/truth_table_probe.md
Name: truth_table_probe

Overview:
- Sequential characterizer for a combinational N-input, 1-output logic circuit, such as the 3-input hex-coded Cello gates.
- Drives every input combination in ascending order, waits a programmable settle time, and samples the circuit output.
- Assembles the results into the circuit's truth-table hex code, using the Cello code convention: row 000 maps to the MSB.
- Optionally compares the result against an expected code. Sits in the test harness around generated circuits; it reads a truth table where the circuit realises one.

Parameters:
- N_IN, 3, number of circuit inputs; code width is 2**N_IN.
- SETTLE_CYCLES, 4, clock cycles each input vector is held; minimum 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a sweep; honoured only in IDLE.
- probe_out  input  1  output of the circuit under test; synchronous to clk.
- expected_code  input  2**N_IN  reference code; sampled at start.
- probe_in  output  N_IN  input vector driven to the circuit under test.
- busy  output  1  high while sweeping.
- done  output  1  one-cycle pulse at sweep completion.
- code  output  2**N_IN  measured truth-table code.
- code_valid  output  1  code holds a complete sweep result.
- match  output  1  code == captured expected_code; meaningful only when code_valid=1.
- mismatch_mask  output  2**N_IN  code XOR captured expected code; zero while code_valid=0.

Behaviour:
- Reset (async assert, deassert sync to clk): state IDLE; probe_in=0, busy=0, done=0, code=0, code_valid=0, match=0, mismatch_mask=0; vector index and settle counter cleared.
- States:
  - IDLE: start=1 at an edge -> SWEEP. Same edge: index=0, settle counter=0, code_valid<=0, code<=0, expected_code captured, busy<=1.
  - SWEEP: probe_in=index. Settle counter increments every cycle. When counter==SETTLE_CYCLES-1:
    - probe_out is written into code bit (2**N_IN-1-index) at that edge;
    - counter resets;
    - if index==2**N_IN-1 -> DONE, else index+1.
  - DONE: single cycle; done=1, busy=0, code_valid=1; mismatch_mask and match valid from this cycle. Next edge -> IDLE.
- Timing: each vector is held exactly SETTLE_CYCLES cycles.
  - Start at edge k: vector i is driven during cycles [k+i*S, k+(i+1)*S) and sampled at edge k+(i+1)*S.
  - done is high in the cycle after edge k+(2**N_IN)*S.
  - Total start-to-done latency: (2**N_IN)*S cycles.
- probe_in holds its last vector (all ones) in DONE, then returns to 0 in IDLE.
- code, code_valid, match and mismatch_mask hold after DONE until the next accepted start.
- start during SWEEP or DONE: ignored. No queueing.
- start held high continuously: a new sweep begins on the first IDLE edge, i.e. one cycle after DONE.
- Reset mid-sweep: immediate abort to reset values; no done pulse; partial code discarded.
- Index counter width: N_IN+1 bits; no wrap occurs because DONE is entered before overflow.

Decomposition:
- Package tt_probe_pkg holds:
  - state enum {IDLE, SWEEP, DONE};
  - function code_bit_index(idx, n_in) returning 2**n_in-1-idx;
  - localparam for code width.
- One sub-module, settle_timer: a counter with parameter SETTLE_CYCLES, inputs clk, rst, clear and enable, and a one-cycle output tick at terminal count.
- The FSM, index and code register stay in truth_table_probe.

Test Plan:
- Behavioural model of code 0xBC (000->1, 001->0, 010->1, 011->1, 100->1, 101->1, 110->0, 111->0), S=4, expected_code=8'hBC, pulse start -> busy high 32 cycles, done pulse in cycle 33, code=8'hBC, match=1, mismatch_mask=8'h00.
- Same model with expected_code=8'hBE -> code=8'hBC, match=0, mismatch_mask=8'h02.
- Constant-1 circuit, SETTLE_CYCLES=1 -> probe_in steps 0..7 on consecutive cycles, done after 8 cycles, code=8'hFF.
- start re-pulsed at cycle 10 of a sweep -> ignored; single done at cycle 33; code unchanged from the uninterrupted result.
- rst asserted mid-sweep (vector 5) -> all outputs 0 immediately, no done. A new start then yields the correct full code, e.g. 8'hBC.
- Two back-to-back sweeps with the circuit changed from 0xBC to 0x01 between them -> code_valid drops at the second start; second result is code=8'h01.
